// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Purpose  : Hazard and sequencing controller for the 5-stage RV32I pipeline.
//            Detects load-use hazards against ID/EX and applies EX redirect
//            flushes. Freezes everything while data memory is busy. Runs a
//            RUN -> DRAIN -> HALTED -> RUN protocol for debug/CSR use.
// Ports    : clk, rst                 clock, synchronous active-high reset
//            id_rs1/rs2, id_uses_*    source operands of the ID instruction
//            ex_rd, ex_MemRead        destination/load flag at ID/EX output
//            ex_redirect              taken branch/jump resolved in EX
//            mem_busy                 data memory stall (global freeze)
//            halt_req, resume_req     halt / resume level requests
//            pc_write, ifid_write     PC and IF/ID load enables
//            ifid_flush, idex_flush   NOP / bubble insertion
//            pipe_hold                hold ID/EX, EX/MEM, MEM/WB
//            halted, ctrl_state       FSM status (RUN=0, DRAIN=1, HALTED=2)
//            stall_cnt, flush_cnt,    event counters (zero unless the
//            freeze_cnt               PIPE_CTRL_PERF_EN macro is defined)
// Config   : PIPE_CTRL_PERF_EN        builds the 32-bit event counters
// Revision : 1.0  initial release
// ============================================================================
module pipeline_ctrl #(
    parameter int DRAIN_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_MemRead,
    input  logic        ex_redirect,
    input  logic        mem_busy,
    input  logic        halt_req,
    input  logic        resume_req,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        pipe_hold,
    output logic        halted,
    output logic [1:0]  ctrl_state,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    output logic [31:0] freeze_cnt
);

    localparam int CW = $clog2(DRAIN_DEPTH);

    localparam logic [1:0] c_RUN    = 2'd0;
    localparam logic [1:0] c_DRAIN  = 2'd1;
    localparam logic [1:0] c_HALTED = 2'd2;

    // A redirect squashes the instruction in ID, so one fewer needs draining.
    localparam logic [CW-1:0] c_CNT_FULL  = CW'(DRAIN_DEPTH - 1);
    localparam logic [CW-1:0] c_CNT_SHORT = CW'(DRAIN_DEPTH - 2);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          w_load_use;

    assign w_load_use = ex_MemRead && (ex_rd != 5'd0) &&
                        ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                         (id_uses_rs2 && (id_rs2 == ex_rd)));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; a memory freeze blocks every transition and holds
    // the drain counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            c_RUN: begin
                if (!mem_busy && halt_req) begin
                    state_d = c_DRAIN;
                    cnt_d   = ex_redirect ? c_CNT_SHORT : c_CNT_FULL;
                end
            end
            c_DRAIN: begin
                if (!mem_busy) begin
                    if (ex_redirect) begin
                        cnt_d = c_CNT_SHORT;
                    end else if (!w_load_use) begin
                        if (cnt_q == '0) begin
                            state_d = c_HALTED;
                        end else begin
                            cnt_d = cnt_q - CW'(1);
                        end
                    end
                end
            end
            c_HALTED: begin
                if (!mem_busy && resume_req) begin
                    state_d = c_RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = c_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        pipe_hold  = 1'b0;
        halted     = (state_q == c_HALTED);
        ctrl_state = state_q;
        if (rst) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            halted     = 1'b0;
            ctrl_state = c_RUN;
        end else if (mem_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
        end else begin
            case (state_q)
                c_DRAIN: begin
                    if (ex_redirect) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (w_load_use) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                    end else begin
                        // Stop fetching; the ID instruction still moves on.
                        pc_write   = 1'b0;
                        ifid_flush = 1'b1;
                    end
                end
                c_HALTED: begin
                    pc_write   = 1'b0;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end
                default: begin
                    if (ex_redirect) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (w_load_use) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    // Events are counted only where the corresponding response is applied,
    // so the three counters follow the same priority as the outputs.
    logic        w_live;
    logic [31:0] stall_q, flush_q, freeze_q;

    assign w_live = (state_q != c_HALTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q  <= 32'd0;
            flush_q  <= 32'd0;
            freeze_q <= 32'd0;
        end else if (mem_busy) begin
            freeze_q <= freeze_q + 32'd1;
        end else if (w_live && ex_redirect) begin
            flush_q  <= flush_q + 32'd1;
        end else if (w_live && w_load_use) begin
            stall_q  <= stall_q + 32'd1;
        end
    end

    assign stall_cnt  = stall_q;
    assign flush_cnt  = flush_q;
    assign freeze_cnt = freeze_q;
`else
    assign stall_cnt  = 32'd0;
    assign flush_cnt  = 32'd0;
    assign freeze_cnt = 32'd0;
`endif

endmodule
`default_nettype wire
